mlp_weight_streamer: RTL and testbench
======================================

MLP_WEIGHT_STREAMER -- requirements
Module: mlp_weight_streamer

Interface
REQ-001 Parameter ADDR_WIDTH, default 6: log2 of the weight memory depth.
REQ-002 Parameter DATA_WIDTH, default 16: weight word width, fixed-point.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-006 base_addr  in  ADDR_WIDTH  first weight address of the burst; sampled with start.
REQ-007 count  in  ADDR_WIDTH+1  number of words to stream, 0..2^ADDR_WIDTH; sampled with start.
REQ-008 busy  out  1  high in every state other than IDLE.
REQ-009 done  out  1  one-cycle pulse when a burst completes.
REQ-010 mem_addr  out  ADDR_WIDTH  read address to the weight memory.
REQ-011 mem_rd_data  in  DATA_WIDTH  weight memory combinational read data for mem_addr.
REQ-012 out_valid  out  1  stream word valid.
REQ-013 out_ready  in  1  downstream accepts the word when out_valid and out_ready are both high.
REQ-014 out_data  out  DATA_WIDTH  stream word.
REQ-015 out_last  out  1  high with the final word of a burst.

Function
REQ-016 States SHALL be IDLE, RUN and DRAIN.
REQ-017 IDLE with start=1 and count>0 SHALL go to RUN next cycle, loading rd_ptr=base_addr and remaining=count.
REQ-018 IDLE with start=1 and count=0 SHALL stay in IDLE and pulse done the next cycle, emitting no words.
REQ-019 start while busy SHALL be ignored.
REQ-020 In RUN, mem_addr SHALL equal rd_ptr; in IDLE and DRAIN, mem_addr SHALL be 0.
REQ-021 In RUN, a fetch SHALL occur in each cycle where the output buffer holds fewer than 2 words, or holds 2 and one is popped that cycle.
REQ-022 A fetch SHALL write mem_rd_data into the buffer, increment rd_ptr modulo 2^ADDR_WIDTH (wrap, no error), and decrement remaining.
REQ-023 The fetch that makes remaining reach 0 SHALL tag its word last and move the FSM to DRAIN.
REQ-024 DRAIN SHALL go to IDLE and pulse done in the cycle after the last-tagged word is popped.
REQ-025 The output buffer SHALL be 2 entries, registered, and first-in first-out; out_data, out_valid and out_last SHALL come from the head entry.
REQ-026 Once out_valid is asserted, out_data and out_last SHALL stay stable until the handshake.
REQ-027 Latency: start in cycle 0 SHALL give out_valid=1 with word base_addr in cycle 2.
REQ-028 Throughput: with out_ready held high, the block SHALL deliver one word per cycle with no bubbles.
REQ-029 A push and a pop in the same cycle SHALL keep the occupancy unchanged.

Reset
REQ-030 Reset asserted SHALL immediately force state=IDLE, busy=0, done=0, out_valid=0, out_last=0, out_data=0, mem_addr=0, rd_ptr=0, remaining=0, and buffer occupancy=0.
REQ-031 Reset mid-burst SHALL discard all buffered words, and no done SHALL follow.
REQ-032 After reset deassertion, the first start SHALL be honoured as in REQ-017 and REQ-018.

Configuration
REQ-033 Macro MLP_WSTREAM_ABORT_EN defined SHALL add input port abort (1 bit).
REQ-034 With MLP_WSTREAM_ABORT_EN defined, abort=1 in RUN or DRAIN SHALL flush the buffer and drop out_valid the next cycle; the FSM SHALL then return to IDLE and pulse done, with out_last never asserted for that burst.
REQ-035 With MLP_WSTREAM_ABORT_EN undefined, the abort port SHALL not exist, and a burst SHALL end only by completion or reset.

Structure
REQ-036 Shared package mlp_pkg SHALL hold the ADDR_WIDTH/DATA_WIDTH defaults and the streamer state encoding (IDLE=0, RUN=1, DRAIN=2).
REQ-037 The 2-entry buffer SHALL be the sub-module mlp_wstream_fifo2, with data, last, push, pop, full, empty, head_valid and an active-low asynchronous reset.
REQ-038 The top level SHALL contain the FSM, rd_ptr, remaining and done generation only.

Verification
REQ-039 Memory mem[i]=i+0x100; start with base=4, count=3, out_ready=1 -> words 0x104, 0x105, 0x106 in cycles 2..4; out_last only on 0x106; done in cycle 5.
REQ-040 base=62, count=4, ADDR_WIDTH=6 -> mem_addr 62, 63, 0, 1; words 0x13E, 0x13F, 0x100, 0x101.
REQ-041 count=0 -> done in cycle 1, out_valid never high, busy stays 0.
REQ-042 count=5, out_ready toggling 1,0,0,1,... -> all 5 words in order, no duplicates, data stable while stalled, never more than 2 buffered.
REQ-043 rst low in the middle of a count=10 burst -> all outputs 0 immediately; a new start afterwards streams correctly.
REQ-044 With MLP_WSTREAM_ABORT_EN: abort after 2 words of a count=8 burst -> out_valid low the next cycle, one done pulse, out_last never seen.

Source files
------------

// File: rtl/mlp_pkg.sv
// mlp_pkg: shared widths and streamer state encoding for the MLP weight path
package mlp_pkg;
  localparam int ADDR_WIDTH_DEF = 6;
  localparam int DATA_WIDTH_DEF = 16;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
endpackage

// File: rtl/mlp_wstream_fifo2.sv
// mlp_wstream_fifo2: 2-entry registered FIFO carrying {last, data}, head drives the stream
//   clk, rst (async active-low), flush: drop all entries next cycle
//   push/data/last: write side; pop: read side (ignored when empty)
//   full, empty, head_valid, head_data, head_last: status and head entry
module mlp_wstream_fifo2 import mlp_pkg::*; #(
  parameter int W = DATA_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] data,
  input  logic         last,
  output logic         full,
  output logic         empty,
  output logic         head_valid,
  output logic [W-1:0] head_data,
  output logic         head_last
);
  logic [W:0] e0, e1;
  logic [1:0] cnt;
  logic do_pop, do_push, to_head;
  always_comb begin
    do_pop = pop && (cnt != 2'd0);
    do_push = push && ((cnt != 2'd2) || do_pop);
    // new word lands at the head when the FIFO is, or is about to become, empty
    to_head = (cnt == 2'd0) || (do_pop && (cnt == 2'd1));
  end
  assign full = cnt == 2'd2;
  assign empty = cnt == 2'd0;
  assign head_valid = !empty;
  assign head_data = e0[W-1:0];
  assign head_last = e0[W] && head_valid;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= 2'd0;
      e0 <= '0;
      e1 <= '0;
    end else if (flush) begin
      cnt <= 2'd0;
      e0 <= '0;
      e1 <= '0;
    end else begin
      cnt <= cnt + 2'(do_push) - 2'(do_pop);
      if (do_pop) e0 <= e1;
      if (do_push && to_head) e0 <= {last, data};
      if (do_push && !to_head) e1 <= {last, data};
    end
endmodule

// File: rtl/mlp_weight_streamer.sv
// mlp_weight_streamer: streams a burst of weight words from memory into a ready/valid port
//   clk, rst (async active-low); start/base_addr/count: burst request, sampled in IDLE
//   busy, done: status; mem_addr/mem_rd_data: combinational weight memory read
//   out_valid/out_ready/out_data/out_last: output stream
//   MLP_WSTREAM_ABORT_EN adds input abort: cancels the running burst
module mlp_weight_streamer import mlp_pkg::*; #(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef MLP_WSTREAM_ABORT_EN
  input  logic                  abort,
`endif
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   count,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);
  localparam logic [ADDR_WIDTH:0] ONE = 1;
  state_t state;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0] remaining;
  logic full, empty, pop, fetch, kill;
`ifdef MLP_WSTREAM_ABORT_EN
  assign kill = abort && (state != IDLE);
`else
  assign kill = 1'b0;
`endif
  assign pop = !empty && out_ready;
  // a full buffer may still fetch when its head leaves this cycle
  assign fetch = (state == RUN) && (!full || pop) && !kill;
  assign busy = state != IDLE;
  assign mem_addr = (state == RUN) ? rd_ptr : '0;
  mlp_wstream_fifo2 #(.W(DATA_WIDTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .flush(kill),
    .push(fetch),
    .pop(pop),
    .data(mem_rd_data),
    .last(remaining == ONE),
    .full(full),
    .empty(empty),
    .head_valid(out_valid),
    .head_data(out_data),
    .head_last(out_last)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      rd_ptr <= '0;
      remaining <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (kill) begin
        state <= IDLE;
        remaining <= '0;
        done <= 1'b1;
      end else if ((state == IDLE) && start) begin
        state <= (count != '0) ? RUN : IDLE;
        rd_ptr <= base_addr;
        remaining <= count;
        done <= count == '0;
      end else if (fetch) begin
        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
        remaining <= remaining - ONE;
        if (remaining == ONE) state <= DRAIN;
      end else if ((state == DRAIN) && pop && out_last) begin
        state <= IDLE;
        done <= 1'b1;
      end
    end
endmodule

// File: tb/tb_mlp_weight_streamer.sv
// tb_mlp_weight_streamer: directed self-checking bench for mlp_weight_streamer (mem[i] = i + 0x100)
module tb_mlp_weight_streamer;
  typedef struct {
    int start, base, cnt, ready;
    int valid, data, last, done, busy, addr;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic out_ready = 1'b0;
  logic [5:0] base_addr = '0;
  logic [6:0] count = '0;
  logic busy, done, out_valid, out_last;
  logic [5:0] mem_addr;
  logic [15:0] mem_rd_data, out_data;
`ifdef MLP_WSTREAM_ABORT_EN
  logic abort = 1'b0;
`endif
  int checks = 0;
  int errors = 0;
  vec_t tbl[$];
  always #5 clk = ~clk;
  assign mem_rd_data = 16'h100 + {10'd0, mem_addr};
  mlp_weight_streamer dut (
    .clk(clk),
    .rst(rst),
`ifdef MLP_WSTREAM_ABORT_EN
    .abort(abort),
`endif
    .start(start),
    .base_addr(base_addr),
    .count(count),
    .busy(busy),
    .done(done),
    .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic idle_outputs(input string nm);
    chk({nm, "_valid"}, out_valid, 0);
    chk({nm, "_last"}, out_last, 0);
    chk({nm, "_data"}, out_data, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_addr"}, mem_addr, 0);
  endtask
  task automatic burst(input int b, input int n, input int mode);
    int k, dones, fetched;
    logic [15:0] held;
    logic hold;
    k = 0;
    dones = 0;
    hold = 1'b0;
    held = '0;
    for (int c = 0; c < 200 && dones == 0; c++) begin
      @(negedge clk);
      start = (c == 0);
      base_addr = 6'(b);
      count = 7'(n);
      out_ready = (mode == 0) || (c % 3 == 0);
      if (hold) chk("stall_stable", out_data, held);
      if (mode == 1 && mem_addr != '0) begin
        fetched = (int'(mem_addr) - b) & 63;
        chk("occupancy", (fetched - k) <= 2, 1);
      end
      if (out_valid && out_ready) begin
        chk("word", out_data, 16'h100 + 16'((b + k) % 64));
        chk("word_last", out_last, k == n - 1);
        k++;
      end
      hold = out_valid && !out_ready;
      held = out_data;
      if (done) begin
        dones++;
        chk("busy_at_done", busy, 0);
      end
    end
    chk("burst_words", k, n);
    chk("burst_done", dones, 1);
    @(negedge clk);
    start = 1'b0;
    chk("done_pulse", done, 0);
  endtask
  initial begin
    #1 idle_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    // base 4, count 3, with an ignored start while busy
    tbl.push_back('{1, 4, 3, 1, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 0, 0, 1, 4});
    tbl.push_back('{1, 10, 5, 1, 1, 'h104, 0, 0, 1, 5});
    tbl.push_back('{0, 0, 0, 1, 1, 'h105, 0, 0, 1, 6});
    tbl.push_back('{0, 0, 0, 1, 1, 'h106, 1, 0, 1, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 0, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 0, 0, 0, 0});
    // base 62, count 4: address wrap
    tbl.push_back('{1, 62, 4, 1, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 0, 0, 1, 62});
    tbl.push_back('{0, 0, 0, 1, 1, 'h13E, 0, 0, 1, 63});
    tbl.push_back('{0, 0, 0, 1, 1, 'h13F, 0, 0, 1, 0});
    tbl.push_back('{0, 0, 0, 1, 1, 'h100, 0, 0, 1, 1});
    tbl.push_back('{0, 0, 0, 1, 1, 'h101, 1, 0, 1, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 0, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 0, 0, 0, 0});
    // count 0: done only
    tbl.push_back('{1, 7, 0, 1, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 0, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 0, 0, 0, 0});
    foreach (tbl[i]) begin
      @(negedge clk);
      start = tbl[i].start[0];
      base_addr = 6'(tbl[i].base);
      count = 7'(tbl[i].cnt);
      out_ready = tbl[i].ready[0];
      chk($sformatf("vec%0d_valid", i), out_valid, tbl[i].valid);
      chk($sformatf("vec%0d_last", i), out_last, tbl[i].last);
      chk($sformatf("vec%0d_done", i), done, tbl[i].done);
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("vec%0d_addr", i), mem_addr, tbl[i].addr);
      if (tbl[i].valid != 0) chk($sformatf("vec%0d_data", i), out_data, tbl[i].data);
    end
    burst(20, 5, 1);
    burst(0, 64, 0);
    // reset in the middle of a count=10 burst
    @(negedge clk);
    start = 1'b1;
    base_addr = 6'd0;
    count = 7'd10;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_valid", out_valid, 1);
    #2 rst = 1'b0;
    #1 idle_outputs("async_reset");
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      idle_outputs("post_reset");
    end
    burst(30, 2, 0);
`ifdef MLP_WSTREAM_ABORT_EN
    @(negedge clk);
    start = 1'b1;
    base_addr = 6'd0;
    count = 7'd8;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("abort_w0", out_data, 16'h100);
    @(negedge clk);
    chk("abort_w1", out_data, 16'h101);
    @(negedge clk);
    abort = 1'b1;
    chk("abort_last", out_last, 0);
    @(negedge clk);
    abort = 1'b0;
    chk("abort_valid", out_valid, 0);
    chk("abort_done", done, 1);
    chk("abort_busy", busy, 0);
    @(negedge clk);
    chk("abort_done_once", done, 0);
    chk("abort_idle_valid", out_valid, 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
